mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous word memory (1-cycle read latency) between the instruction-fetch port and the load/store port of the RISC-V core.
- Holds both ports stalled until the memory reports preload complete.
- Uses load/store-first priority, with a starvation guard for fetch.
- Sits between the core pipeline and the code/data memory.

Parameters:
- AW, 14: word-address width of the memory. Memory covers 2^(AW+2) bytes.
- MAX_WAIT, 4: consecutive cycles fetch may be denied before it receives forced priority (range 1..15).
- CODE_LIMIT, 32'h0000_4000: byte address; addresses below it are the code region. Used only by the optional feature.

Ports:
- I_clk in 1: clock.
- I_rst in 1: synchronous, active-high reset.
- I_if_req in 1: fetch request. Held with address while O_if_stall=1.
- I_if_addr in 32: fetch byte address. Bits [1:0] ignored.
- O_if_data out 32: fetched word. Valid when O_if_valid=1.
- O_if_valid out 1: fetch response, one cycle after acceptance.
- O_if_stall out 1: fetch not accepted this cycle.
- I_ls_req in 1: load/store request. Held with all fields while O_ls_stall=1.
- I_ls_we in 1: 1 = store, 0 = load.
- I_ls_addr in 32: load/store byte address. Bits [1:0] ignored.
- I_ls_wdata in 32: store data.
- I_ls_wmask in 4: store byte enables.
- O_ls_data out 32: load data. 0 for store acknowledge.
- O_ls_valid out 1: load/store response, one cycle after acceptance.
- O_ls_stall out 1: load/store not accepted this cycle.
- O_ls_fault out 1: store dropped (optional feature). Pulses with O_ls_valid.
- O_mem_en out 1: memory access strobe.
- O_mem_we out 4: memory byte write enables.
- O_mem_addr out AW: memory word address = addr[AW+1:2].
- O_mem_wdata out 32: memory write data.
- I_mem_rdata in 32: memory read data, valid the cycle after O_mem_en.
- I_mem_ready in 1: memory preload complete. Level signal.

Behaviour:

Reset (I_rst=1):
- state=INIT, wait counter=0, response registers cleared.
- O_if_stall=1, O_ls_stall=1; O_if_valid=0, O_ls_valid=0, O_ls_fault=0.
- O_if_data=0, O_ls_data=0; O_mem_en=0, O_mem_we=0.
- Reset mid-operation drops any in-flight response: no valid pulse follows reset.

States:
- INIT: both stalls high, no memory access. Moves to RUN the cycle after I_mem_ready is sampled 1.
- RUN: arbitration active. If I_mem_ready drops in RUN, go back to INIT from the next cycle; an access granted in the same cycle still completes.

Grant, combinational in RUN:
- grant_ls = I_ls_req & ~(force_if & I_if_req).
- grant_if = I_if_req & ~grant_ls.
- force_if = (wait counter >= MAX_WAIT).

Stalls:
- O_if_stall = ~RUN | (I_if_req & ~grant_if).
- O_ls_stall = ~RUN | (I_ls_req & ~grant_ls).
- With no request, stall is low in RUN.

Memory side, driven combinationally from the granted port in the grant cycle:
- O_mem_en = grant_if | grant_ls.
- O_mem_we = I_ls_wmask if grant_ls & I_ls_we, else 0.
- O_mem_addr and O_mem_wdata come from the granted port.
- Ungranted cycles: O_mem_en=0, O_mem_we=0.

Response:
- Registered: grant id and store flag captured at the grant edge.
- Next cycle, exactly one of O_if_valid / O_ls_valid is 1.
- Data outputs pass I_mem_rdata through; O_ls_data=0 on a store acknowledge.
- When not valid, data outputs are 0.
- Back-to-back grants give one response per cycle; throughput is 1 access/cycle.

Wait counter (4-bit):
- Increments each RUN cycle with I_if_req=1 & grant_if=0, saturating at 15.
- Clears on grant_if or when I_if_req=0.

Simultaneous requests, counter < MAX_WAIT: load/store wins and fetch stalls.

Optional Feature:
- Macro: LS_WRITE_PROTECT_EN.
- Defined: a granted store with I_ls_addr < CODE_LIMIT gets O_mem_en=0 and O_mem_we=0.
  - It is still acknowledged next cycle: O_ls_valid=1, O_ls_fault=1, O_ls_data=0.
  - Loads are never blocked.
- Undefined: all stores are written; O_ls_fault is tied 0.

Test Plan:
- Reset then I_mem_ready=0 for 20 cycles with both requests high -> both stalls 1, O_mem_en 0. Raise ready -> first grant on the 2nd cycle after the rise.
- Fetch only, addresses 0x0, 0x4, 0x8 on consecutive cycles, memory preloaded 0x00000013/0x00100093/0x00200113 -> O_if_valid 1 on three consecutive cycles, each one cycle after issue, data in order; O_mem_addr 0, 1, 2.
- Continuous ls load plus continuous fetch, MAX_WAIT=4 -> ls granted 4 cycles, fetch granted on cycle 5, counter clears; pattern repeats every 5 cycles.
- Store I_ls_addr=0x8000, wdata=0xDEADBEEF, wmask=4'b0011 -> O_mem_we=4'b0011 that cycle, O_ls_valid=1 & O_ls_data=0 next cycle. Later load from 0x8000 returns low half 0xBEEF.
- Assert I_rst the cycle after a fetch grant -> no O_if_valid pulse, all outputs at reset values, state INIT.
- With LS_WRITE_PROTECT_EN, store to 0x100 -> O_mem_we=0, O_ls_fault=1 next cycle, memory unchanged. Without the macro, same store writes and O_ls_fault stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port word memory between instruction fetch and load/store.
// Optional store write-protection of the code region: define LS_WRITE_PROTECT_EN.
module mem_port_arbiter #(
  parameter int          AW         = 14,
  parameter int          MAX_WAIT   = 4,
  parameter logic [31:0] CODE_LIMIT = 32'h0000_4000
) (
  input  logic          I_clk,
  input  logic          I_rst,
  input  logic          I_if_req,
  input  logic [31:0]   I_if_addr,
  output logic [31:0]   O_if_data,
  output logic          O_if_valid,
  output logic          O_if_stall,
  input  logic          I_ls_req,
  input  logic          I_ls_we,
  input  logic [31:0]   I_ls_addr,
  input  logic [31:0]   I_ls_wdata,
  input  logic [3:0]    I_ls_wmask,
  output logic [31:0]   O_ls_data,
  output logic          O_ls_valid,
  output logic          O_ls_stall,
  output logic          O_ls_fault,
  output logic          O_mem_en,
  output logic [3:0]    O_mem_we,
  output logic [AW-1:0] O_mem_addr,
  output logic [31:0]   O_mem_wdata,
  input  logic [31:0]   I_mem_rdata,
  input  logic          I_mem_ready
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t     state, state_nx;
  logic [3:0] wait_cnt;
  logic       run, force_if, grant_ls, grant_if, ls_block;
  logic       if_vld_p1, ls_vld_p1, st_p1, flt_p1;
  logic       unused_bits;

  always_ff @(posedge I_clk) begin
    if (I_rst) state <= INIT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      INIT: if (I_mem_ready)  state_nx = RUN;
      RUN:  if (!I_mem_ready) state_nx = INIT;
      default: state_nx = INIT;
    endcase
  end

  // Grant stage (p0): reset masks everything so outputs hold reset values at once
  always_comb begin
    run      = (state == RUN) & ~I_rst;
    force_if = (wait_cnt >= MAX_WAIT_C);
    grant_ls = run & I_ls_req & ~(force_if & I_if_req);
    grant_if = run & I_if_req & ~grant_ls;
  end

`ifdef LS_WRITE_PROTECT_EN
  assign ls_block = grant_ls & I_ls_we & (I_ls_addr < CODE_LIMIT);
`else
  assign ls_block = 1'b0;
`endif

  assign O_if_stall  = ~run | (I_if_req & ~grant_if);
  assign O_ls_stall  = ~run | (I_ls_req & ~grant_ls);
  assign O_mem_en    = (grant_if | grant_ls) & ~ls_block;
  assign O_mem_we    = (grant_ls & I_ls_we & ~ls_block) ? I_ls_wmask : 4'b0000;
  assign O_mem_addr  = grant_ls ? I_ls_addr[AW+1:2] : I_if_addr[AW+1:2];
  assign O_mem_wdata = I_ls_wdata;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      wait_cnt <= 4'd0;
    end else if (run && I_if_req && !grant_if) begin
      if (wait_cnt != 4'hF) wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= 4'd0;
    end
  end

  // Response stage (p1): memory data arrives one cycle after the grant
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      if_vld_p1 <= 1'b0;
      ls_vld_p1 <= 1'b0;
      st_p1     <= 1'b0;
      flt_p1    <= 1'b0;
    end else begin
      if_vld_p1 <= grant_if;
      ls_vld_p1 <= grant_ls;
      st_p1     <= grant_ls & I_ls_we;
      flt_p1    <= ls_block;
    end
  end

  assign O_if_valid = if_vld_p1 & ~I_rst;
  assign O_ls_valid = ls_vld_p1 & ~I_rst;
  assign O_if_data  = O_if_valid ? I_mem_rdata : 32'd0;
  assign O_ls_data  = (O_ls_valid & ~st_p1) ? I_mem_rdata : 32'd0;
  assign O_ls_fault = O_ls_valid & flt_p1;

  assign unused_bits = ^{I_if_addr[31:AW+2], I_if_addr[1:0],
                         I_ls_addr[31:AW+2], I_ls_addr[1:0], CODE_LIMIT};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed table-driven bench for mem_port_arbiter with a behavioural word memory.
module tb_mem_port_arbiter;

  localparam int AW = 14;
`ifdef LS_WRITE_PROTECT_EN
  localparam logic PROT = 1'b1;
`else
  localparam logic PROT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, if_req, ls_req, ls_we, mem_ready, load_mem;
  logic [31:0]   if_addr, ls_addr, ls_wdata, if_data, ls_data, mem_wdata, mem_rdata;
  logic [3:0]    ls_wmask, mem_we;
  logic          if_valid, if_stall, ls_valid, ls_stall, ls_fault, mem_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem [0:(1<<AW)-1];
  int            n_vec = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .MAX_WAIT(4), .CODE_LIMIT(32'h0000_4000)) dut (
    .I_clk(clk), .I_rst(rst),
    .I_if_req(if_req), .I_if_addr(if_addr), .O_if_data(if_data),
    .O_if_valid(if_valid), .O_if_stall(if_stall),
    .I_ls_req(ls_req), .I_ls_we(ls_we), .I_ls_addr(ls_addr),
    .I_ls_wdata(ls_wdata), .I_ls_wmask(ls_wmask), .O_ls_data(ls_data),
    .O_ls_valid(ls_valid), .O_ls_stall(ls_stall), .O_ls_fault(ls_fault),
    .O_mem_en(mem_en), .O_mem_we(mem_we), .O_mem_addr(mem_addr),
    .O_mem_wdata(mem_wdata), .I_mem_rdata(mem_rdata), .I_mem_ready(mem_ready)
  );

  always @(posedge clk) begin
    if (load_mem) begin
      mem[0]       <= 32'h0000_0013;
      mem[1]       <= 32'h0010_0093;
      mem[2]       <= 32'h0020_0113;
      mem[14'h40]  <= 32'hCAFE_F00D;
      mem[14'h2000] <= 32'h1122_3344;
    end else if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  typedef struct {
    string       nm;
    logic        rst, rdy, ifr;
    logic [31:0] ifa;
    logic        lsr, we;
    logic [31:0] lsa, wd;
    logic [3:0]  wm;
    logic        e_ifs, e_lss, e_en;
    logic [3:0]  e_we;
    logic [13:0] e_addr;
    logic        e_ifv;
    logic [31:0] e_ifd;
    logic        e_lsv;
    logic [31:0] e_lsd;
    logic        e_flt;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic r, rdy, ifr, input logic [31:0] ifa,
                              input logic lsr, we, input logic [31:0] lsa, wd, input logic [3:0] wm,
                              input logic ifs, lss, en, input logic [3:0] ewe, input logic [13:0] ea,
                              input logic ifv, input logic [31:0] ifd, input logic lsv,
                              input logic [31:0] lsd, input logic flt);
    vec_t v;
    v.nm = nm; v.rst = r; v.rdy = rdy; v.ifr = ifr; v.ifa = ifa;
    v.lsr = lsr; v.we = we; v.lsa = lsa; v.wd = wd; v.wm = wm;
    v.e_ifs = ifs; v.e_lss = lss; v.e_en = en; v.e_we = ewe; v.e_addr = ea;
    v.e_ifv = ifv; v.e_ifd = ifd; v.e_lsv = lsv; v.e_lsd = lsd; v.e_flt = flt;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [119:0] obs, exp_v;
    @(negedge clk);
    rst = v.rst; mem_ready = v.rdy; if_req = v.ifr; if_addr = v.ifa;
    ls_req = v.lsr; ls_we = v.we; ls_addr = v.lsa; ls_wdata = v.wd; ls_wmask = v.wm;
    #2;
    obs   = {if_stall, ls_stall, mem_en, mem_we, v.e_en ? mem_addr : 14'd0,
             (v.e_we != 4'd0) ? mem_wdata : 32'd0,
             if_valid, if_data, ls_valid, ls_data, ls_fault};
    exp_v = {v.e_ifs, v.e_lss, v.e_en, v.e_we, v.e_en ? v.e_addr : 14'd0,
             (v.e_we != 4'd0) ? v.wd : 32'd0,
             v.e_ifv, v.e_ifd, v.e_lsv, v.e_lsd, v.e_flt};
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", v.nm, obs, exp_v);
    end
  endtask

  vec_t tbl [0:27];

  initial begin
    // cols: rst rdy ifr ifa  lsr we lsa wd wm | ifs lss en we addr | ifv ifd lsv lsd flt
    tbl[0]  = mk("ready_rise", 0,1,1,32'h0, 1,0,32'h8000,0,0, 1,1,0,0,0,       0,0,0,0,0);
    tbl[1]  = mk("ls_first",   0,1,1,32'h0, 1,0,32'h8000,0,0, 1,0,1,0,14'h2000, 0,0,0,0,0);
    tbl[2]  = mk("ls_2",       0,1,1,32'h0, 1,0,32'h8000,0,0, 1,0,1,0,14'h2000, 0,0,1,32'h11223344,0);
    tbl[3]  = mk("ls_3",       0,1,1,32'h0, 1,0,32'h8000,0,0, 1,0,1,0,14'h2000, 0,0,1,32'h11223344,0);
    tbl[4]  = mk("ls_4",       0,1,1,32'h0, 1,0,32'h8000,0,0, 1,0,1,0,14'h2000, 0,0,1,32'h11223344,0);
    tbl[5]  = mk("force_if",   0,1,1,32'h0, 1,0,32'h8000,0,0, 0,1,1,0,14'h0,    0,0,1,32'h11223344,0);
    tbl[6]  = mk("ls_again",   0,1,1,32'h0, 1,0,32'h8000,0,0, 1,0,1,0,14'h2000, 1,32'h13,0,0,0);
    tbl[7]  = mk("ls_b2",      0,1,1,32'h0, 1,0,32'h8000,0,0, 1,0,1,0,14'h2000, 0,0,1,32'h11223344,0);
    tbl[8]  = mk("ls_b3",      0,1,1,32'h0, 1,0,32'h8000,0,0, 1,0,1,0,14'h2000, 0,0,1,32'h11223344,0);
    tbl[9]  = mk("ls_b4",      0,1,1,32'h0, 1,0,32'h8000,0,0, 1,0,1,0,14'h2000, 0,0,1,32'h11223344,0);
    tbl[10] = mk("force_if2",  0,1,1,32'h0, 1,0,32'h8000,0,0, 0,1,1,0,14'h0,    0,0,1,32'h11223344,0);
    tbl[11] = mk("idle_resp",  0,1,0,32'h0, 0,0,0,0,0,        0,0,0,0,0,        1,32'h13,0,0,0);
    tbl[12] = mk("fetch_0",    0,1,1,32'h0, 0,0,0,0,0,        0,0,1,0,14'h0,    0,0,0,0,0);
    tbl[13] = mk("fetch_4",    0,1,1,32'h4, 0,0,0,0,0,        0,0,1,0,14'h1,    1,32'h13,0,0,0);
    tbl[14] = mk("fetch_8",    0,1,1,32'h8, 0,0,0,0,0,        0,0,1,0,14'h2,    1,32'h00100093,0,0,0);
    tbl[15] = mk("fetch_last", 0,1,0,32'h0, 0,0,0,0,0,        0,0,0,0,0,        1,32'h00200113,0,0,0);
    tbl[16] = mk("store_half", 0,1,0,32'h0, 1,1,32'h8000,32'hDEADBEEF,4'b0011, 0,0,1,4'b0011,14'h2000, 0,0,0,0,0);
    tbl[17] = mk("store_ack",  0,1,0,32'h0, 0,0,0,0,0,        0,0,0,0,0,        0,0,1,32'h0,0);
    tbl[18] = mk("load_back",  0,1,0,32'h0, 1,0,32'h8000,0,0, 0,0,1,0,14'h2000, 0,0,0,0,0);
    tbl[19] = mk("load_data",  0,1,0,32'h0, 0,0,0,0,0,        0,0,0,0,0,        0,0,1,32'h1122BEEF,0);
    tbl[20] = mk("store_code", 0,1,0,32'h0, 1,1,32'h100,32'h12345678,4'hF,
                 0,0,!PROT,PROT ? 4'h0 : 4'hF,14'h40, 0,0,0,0,0);
    tbl[21] = mk("code_ack",   0,1,0,32'h0, 1,0,32'h100,0,0,  0,0,1,0,14'h40,   0,0,1,32'h0,PROT);
    tbl[22] = mk("code_load",  0,1,0,32'h0, 0,0,0,0,0,        0,0,0,0,0,
                 0,0,1,PROT ? 32'hCAFEF00D : 32'h12345678,0);
    tbl[23] = mk("rdy_drop",   0,0,1,32'h4, 0,0,0,0,0,        0,0,1,0,14'h1,    0,0,0,0,0);
    tbl[24] = mk("rdy_init",   0,0,1,32'h4, 0,0,0,0,0,        1,1,0,0,0,        1,32'h00100093,0,0,0);
    tbl[25] = mk("rdy_back",   0,1,1,32'h4, 0,0,0,0,0,        1,1,0,0,0,        0,0,0,0,0);
    tbl[26] = mk("rdy_grant",  0,1,1,32'h4, 0,0,0,0,0,        0,0,1,0,14'h1,    0,0,0,0,0);
    tbl[27] = mk("rdy_resp",   0,1,0,32'h0, 0,0,0,0,0,        0,0,0,0,0,        1,32'h00100093,0,0,0);

    load_mem = 1'b1;
    rst = 1'b1; mem_ready = 1'b1; if_req = 1'b1; if_addr = 32'h0;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h8000; ls_wdata = 32'h0; ls_wmask = 4'h0;

    for (int i = 0; i < 3; i++)
      run_vec(mk("reset_state", 1,1,1,32'h0, 1,0,32'h8000,0,0, 1,1,0,0,0, 0,0,0,0,0));
    load_mem = 1'b0;

    for (int i = 0; i < 20; i++)
      run_vec(mk("init_hold", 0,0,1,32'h0, 1,0,32'h8000,0,0, 1,1,0,0,0, 0,0,0,0,0));

    for (int i = 0; i < 28; i++)
      run_vec(tbl[i]);

    // Reset one cycle after a fetch grant must swallow the response
    run_vec(mk("pre_rst_fetch", 0,1,1,32'h8, 0,0,0,0,0, 0,0,1,0,14'h2, 0,0,0,0,0));
    run_vec(mk("rst_drop",      1,1,1,32'h8, 0,0,0,0,0, 1,1,0,0,0,     0,0,0,0,0));
    run_vec(mk("rst_init",      0,1,1,32'h8, 0,0,0,0,0, 1,1,0,0,0,     0,0,0,0,0));
    run_vec(mk("rst_regrant",   0,1,1,32'h8, 0,0,0,0,0, 0,0,1,0,14'h2, 0,0,0,0,0));
    run_vec(mk("rst_resp",      0,1,0,32'h0, 0,0,0,0,0, 0,0,0,0,0,     1,32'h00200113,0,0,0));
    run_vec(mk("quiet",         0,1,0,32'h0, 0,0,0,0,0, 0,0,0,0,0,     0,0,0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
